// File: rtl/haze_param_gen.sv
// haze_param_gen
//   Per-pixel dark-channel haze estimator. It produces a transmission
//   estimate t2 for each pixel through a fixed 3-stage pipeline. It also
//   tracks the brightest dark-channel value of each frame and uses it as the
//   atmospheric-light estimate for the following frame.
//
// Ports
//   clk, nrst                 clock; asynchronous active-low reset
//   hsync, vsync, en          input video timing (en marks a valid pixel)
//   r, g, b                   hazy pixel components
//   o_r, o_g, o_b             pixel components aligned with t2
//   o_hsync, o_vsync, o_en    timing aligned with t2
//   t2                        transmission estimate (255 = fully clear)
//   max_of_dark               atmospheric-light estimate (255 until latched)
//   a_valid                   set once a frame estimate has been latched
module haze_param_gen #(
  parameter logic [7:0] OMEGA = 8'd243,
  parameter logic [7:0] T_MIN = 8'd26
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       hsync,
  input  logic       vsync,
  input  logic       en,
  input  logic [7:0] r,
  input  logic [7:0] g,
  input  logic [7:0] b,
  output logic [7:0] o_r,
  output logic [7:0] o_g,
  output logic [7:0] o_b,
  output logic [7:0] t2,
  output logic [7:0] max_of_dark,
  output logic       a_valid,
  output logic       o_hsync,
  output logic       o_vsync,
  output logic       o_en
);

  function automatic logic [7:0] min2(input logic [7:0] x, input logic [7:0] y);
    return (x < y) ? x : y;
  endfunction

  function automatic logic [7:0] max2(input logic [7:0] x, input logic [7:0] y);
    return (x > y) ? x : y;
  endfunction

  // Stage 1 registers
  logic [7:0]  dark_s1_r, r_s1_r, g_s1_r, b_s1_r;
  logic        hs_s1_r, vs_s1_r, en_s1_r;
  // Stage 2 registers
  logic [15:0] prod_s2_r;
  logic [7:0]  r_s2_r, g_s2_r, b_s2_r;
  logic        hs_s2_r, vs_s2_r, en_s2_r;
  // Frame-statistics state
  logic [7:0]  run_max_r;
  logic        seen_r;
  logic        vsync_d_r;
  logic        vs_armed_r;

  logic [7:0]  dark_s;
  logic [7:0]  inv_s;
  logic [7:0]  t2_s;
  logic        vs_edge_s;
  logic        seen_now_s;
  logic [7:0]  cand_s;

  // Combinational pixel math: dark channel, then inverted and floored transmission
  always_comb begin
    dark_s = min2(min2(r, g), b);
    // OMEGA fits in 8 bits, so prod_s2_r[15:8] never exceeds 254: no underflow
    inv_s  = 8'd255 - prod_s2_r[15:8];
    if (inv_s < T_MIN) begin
      t2_s = T_MIN;
    end else begin
      t2_s = inv_s;
    end
  end

  // Combinational frame control: vsync edge detect and candidate frame maximum
  always_comb begin
    // vs_armed_r keeps a vsync already high at reset release from counting as an edge
    vs_edge_s  = vsync & ~vsync_d_r & vs_armed_r;
    seen_now_s = seen_r | en_s1_r;
    if (en_s1_r) begin
      cand_s = max2(run_max_r, dark_s1_r);
    end else begin
      cand_s = run_max_r;
    end
  end

  // Three-stage pixel pipeline, free-running regardless of en
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      dark_s1_r <= 8'd0;
      r_s1_r    <= 8'd0;
      g_s1_r    <= 8'd0;
      b_s1_r    <= 8'd0;
      hs_s1_r   <= 1'b0;
      vs_s1_r   <= 1'b0;
      en_s1_r   <= 1'b0;
      prod_s2_r <= 16'd0;
      r_s2_r    <= 8'd0;
      g_s2_r    <= 8'd0;
      b_s2_r    <= 8'd0;
      hs_s2_r   <= 1'b0;
      vs_s2_r   <= 1'b0;
      en_s2_r   <= 1'b0;
      t2        <= 8'd0;
      o_r       <= 8'd0;
      o_g       <= 8'd0;
      o_b       <= 8'd0;
      o_hsync   <= 1'b0;
      o_vsync   <= 1'b0;
      o_en      <= 1'b0;
    end else begin
      dark_s1_r <= dark_s;
      r_s1_r    <= r;
      g_s1_r    <= g;
      b_s1_r    <= b;
      hs_s1_r   <= hsync;
      vs_s1_r   <= vsync;
      en_s1_r   <= en;
      prod_s2_r <= {8'd0, dark_s1_r} * {8'd0, OMEGA};
      r_s2_r    <= r_s1_r;
      g_s2_r    <= g_s1_r;
      b_s2_r    <= b_s1_r;
      hs_s2_r   <= hs_s1_r;
      vs_s2_r   <= vs_s1_r;
      en_s2_r   <= en_s1_r;
      t2        <= t2_s;
      o_r       <= r_s2_r;
      o_g       <= g_s2_r;
      o_b       <= b_s2_r;
      o_hsync   <= hs_s2_r;
      o_vsync   <= vs_s2_r;
      o_en      <= en_s2_r;
    end
  end

  // Frame maximum tracking and latch of the atmospheric-light estimate.
  // max_of_dark itself holds the latched estimate; 255 means none yet.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      vsync_d_r   <= 1'b0;
      vs_armed_r  <= 1'b0;
      run_max_r   <= 8'd0;
      seen_r      <= 1'b0;
      a_valid     <= 1'b0;
      max_of_dark <= 8'd255;
    end else begin
      vsync_d_r  <= vsync;
      vs_armed_r <= vs_armed_r | ~vsync;
      if (vs_edge_s) begin
        // The pixel in stage 1 on the edge cycle closes the old frame
        run_max_r <= 8'd0;
        seen_r    <= 1'b0;
        if (seen_now_s) begin
          a_valid     <= 1'b1;
          max_of_dark <= cand_s;
        end else begin
          a_valid     <= a_valid;
          max_of_dark <= max_of_dark;
        end
      end else if (en_s1_r) begin
        run_max_r <= cand_s;
        seen_r    <= 1'b1;
      end else begin
        run_max_r <= run_max_r;
        seen_r    <= seen_r;
      end
    end
  end

endmodule

// File: tb/tb_haze_param_gen.sv
module tb_haze_param_gen;

  logic       clk = 1'b0;
  logic       nrst;
  logic       hsync, vsync, en;
  logic [7:0] r, g, b;
  logic [7:0] o_r, o_g, o_b, t2, max_of_dark;
  logic       a_valid, o_hsync, o_vsync, o_en;
  logic [7:0] z_r, z_g, z_b, z_t2, z_mod;
  logic       z_valid, z_hsync, z_vsync, z_en;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  haze_param_gen u_dut (
    .clk(clk), .nrst(nrst), .hsync(hsync), .vsync(vsync), .en(en),
    .r(r), .g(g), .b(b), .o_r(o_r), .o_g(o_g), .o_b(o_b), .t2(t2),
    .max_of_dark(max_of_dark), .a_valid(a_valid),
    .o_hsync(o_hsync), .o_vsync(o_vsync), .o_en(o_en)
  );

  haze_param_gen #(.OMEGA(8'd243), .T_MIN(8'd0)) u_dut_z (
    .clk(clk), .nrst(nrst), .hsync(hsync), .vsync(vsync), .en(en),
    .r(r), .g(g), .b(b), .o_r(z_r), .o_g(z_g), .o_b(z_b), .t2(z_t2),
    .max_of_dark(z_mod), .a_valid(z_valid),
    .o_hsync(z_hsync), .o_vsync(z_vsync), .o_en(z_en)
  );

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Apply one pixel (hsync follows en) and advance one clock; returns 1 time unit after the edge.
  task automatic pix(input logic [7:0] pr, input logic [7:0] pg, input logic [7:0] pb,
                     input logic pe, input logic pv);
    r = pr; g = pg; b = pb; en = pe; hsync = pe; vsync = pv;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic pv);
    pix(8'd0, 8'd0, 8'd0, 1'b0, pv);
  endtask

  initial begin
    nrst = 1'b0;
    r = 8'd0; g = 8'd0; b = 8'd0; en = 1'b0; hsync = 1'b0; vsync = 1'b0;
    #12;
    check_val("rst_t2", t2, 0);
    check_val("rst_o_r", o_r, 0);
    check_val("rst_o_en", o_en, 0);
    check_val("rst_mod", max_of_dark, 255);
    check_val("rst_valid", a_valid, 0);
    #1 nrst = 1'b1;

    // Frame with en never high, then an edge: estimate must stay unset
    idle(1'b0); idle(1'b0); idle(1'b1); idle(1'b0);
    check_val("noen_mod", max_of_dark, 255);
    check_val("noen_valid", a_valid, 0);

    // Basic pixel: dark 200 -> 48600>>8 = 189 -> t2 = 66
    pix(8'd200, 8'd220, 8'd240, 1'b1, 1'b0);
    idle(1'b0); idle(1'b0);
    check_val("px_t2", t2, 66);
    check_val("px_o_r", o_r, 200);
    check_val("px_o_g", o_g, 220);
    check_val("px_o_b", o_b, 240);
    check_val("px_o_en", o_en, 1);
    check_val("px_o_hsync", o_hsync, 1);
    check_val("px_o_vsync", o_vsync, 0);
    check_val("px_z_t2", z_t2, 66);

    // Boundaries: dark 0 -> 255; dark 255 -> 13, floored to 26 (13 with T_MIN=0)
    pix(8'd0, 8'd5, 8'd9, 1'b1, 1'b0);
    pix(8'd255, 8'd255, 8'd255, 1'b1, 1'b0);
    pix(8'd255, 8'd255, 8'd255, 1'b0, 1'b0);
    check_val("dark0_t2", t2, 255);
    check_val("dark0_o_g", o_g, 5);
    idle(1'b0);
    check_val("dark255_t2", t2, 26);
    check_val("dark255_z_t2", z_t2, 13);
    check_val("dark255_o_en", o_en, 1);
    idle(1'b0);
    check_val("en0_o_en", o_en, 0);
    check_val("en0_t2", t2, 26);
    check_val("preedge_mod", max_of_dark, 255);
    check_val("preedge_valid", a_valid, 0);

    // First real edge: frame maximum was 255
    idle(1'b1);
    check_val("edge1_mod", max_of_dark, 255);
    check_val("edge1_valid", a_valid, 1);

    // Frame 10,180,90 sent while vsync stays high: only one edge
    pix(8'd10, 8'd20, 8'd30, 1'b1, 1'b1);
    pix(8'd180, 8'd190, 8'd200, 1'b1, 1'b1);
    check_val("hold_o_vsync", o_vsync, 1);
    pix(8'd90, 8'd100, 8'd110, 1'b1, 1'b1);
    idle(1'b0);
    check_val("mid_frame_mod", max_of_dark, 255);
    idle(1'b1);
    check_val("frame180_mod", max_of_dark, 180);
    check_val("frame180_valid", a_valid, 1);

    // Following frame with darks 50,30: run_max must have restarted
    pix(8'd60, 8'd50, 8'd70, 1'b1, 1'b1);
    pix(8'd30, 8'd40, 8'd35, 1'b1, 1'b1);
    idle(1'b0); idle(1'b1);
    check_val("frame50_mod", max_of_dark, 50);

    // vsync toggling with no en between edges leaves the estimate unchanged
    idle(1'b0); idle(1'b1); idle(1'b0); idle(1'b1);
    check_val("toggle_mod", max_of_dark, 50);
    check_val("toggle_valid", a_valid, 1);

    // Same-cycle pixel (dark 200) on the edge with run_max 120
    pix(8'd120, 8'd130, 8'd140, 1'b1, 1'b0);
    pix(8'd200, 8'd210, 8'd220, 1'b1, 1'b0);
    idle(1'b1);
    check_val("samecyc_mod", max_of_dark, 200);
    idle(1'b0);
    pix(8'd7, 8'd8, 8'd9, 1'b1, 1'b0);
    idle(1'b0); idle(1'b1);
    check_val("newframe_mod", max_of_dark, 7);

    // Asynchronous reset mid-frame with a full pipeline
    pix(8'd100, 8'd110, 8'd120, 1'b1, 1'b0);
    pix(8'd101, 8'd111, 8'd121, 1'b1, 1'b0);
    pix(8'd102, 8'd112, 8'd122, 1'b1, 1'b0);
    check_val("full_o_r", o_r, 100);
    #2 nrst = 1'b0;
    #1;
    check_val("arst_o_r", o_r, 0);
    check_val("arst_o_b", o_b, 0);
    check_val("arst_t2", t2, 0);
    check_val("arst_o_en", o_en, 0);
    check_val("arst_o_hsync", o_hsync, 0);
    check_val("arst_mod", max_of_dark, 255);
    check_val("arst_valid", a_valid, 0);

    // Release with vsync already high: no edge until vsync has been seen low
    vsync = 1'b1;
    nrst = 1'b1;
    pix(8'd40, 8'd50, 8'd60, 1'b1, 1'b1);
    idle(1'b1); idle(1'b1);
    check_val("arm_valid", a_valid, 0);
    check_val("arm_mod", max_of_dark, 255);
    idle(1'b0); idle(1'b1);
    check_val("armed_mod", max_of_dark, 40);
    check_val("armed_valid", a_valid, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
